// File: rtl/ppu_ctrl.sv
// Job sequencer between the psum buffer, the PPU and the ofmap buffer.
// It streams num_elem psums into the PPU and packs the int8 results four to a word.
module ppu_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_elem,
  input  logic [ADDR_W-1:0] psum_base,
  input  logic [ADDR_W-1:0] ofmap_base,
  input  logic [11:0]       scale_in,
  output logic              psum_rd_en,
  output logic [ADDR_W-1:0] psum_rd_addr,
  input  logic [31:0]       psum_rd_data,
  output logic              ppu_en,
  output logic [31:0]       ppu_data,
  output logic [11:0]       ppu_scale,
  input  logic [7:0]        ppu_q,
  input  logic              ppu_valid,
  output logic              ofmap_wr_en,
  output logic [ADDR_W-1:0] ofmap_wr_addr,
  output logic [31:0]       ofmap_wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [11:0]       scale_q, scale_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic              ppu_en_q, ppu_en_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_last_q, wr_last_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              byte_ok;
  logic              last_byte;
  logic [31:0]       word;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    scale_d   = scale_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    rd_cnt_d  = rd_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    ppu_en_d  = (state_q == S_ISSUE);
    wr_en_d   = 1'b0;
    wr_last_d = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    // Received bytes are counted on their own, so the packer never trusts read timing.
    byte_ok   = ppu_valid && (state_q == S_ISSUE || state_q == S_DRAIN);
    last_byte = (rcv_cnt_q + CNT_W'(1)) == num_q;
    word      = pack_q | (32'(ppu_q) << {lane_q, 3'b000});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_elem;
          scale_d   = scale_in;
          raddr_d   = psum_base;
          waddr_d   = ofmap_base;
          rd_cnt_d  = '0;
          rcv_cnt_d = '0;
          lane_d    = '0;
          pack_d    = '0;
          state_d   = (num_elem == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        raddr_d  = raddr_q + ADDR_W'(1);
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (rd_cnt_q == num_q - CNT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_en_q && wr_last_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (byte_ok) begin
      rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
      if (lane_q == 2'd3 || last_byte) begin
        wr_en_d   = 1'b1;
        wr_last_d = last_byte;
        wr_addr_d = waddr_q;
        wr_data_d = word;
        waddr_d   = waddr_q + ADDR_W'(1);
        pack_d    = '0;
        lane_d    = '0;
      end else begin
        pack_d = word;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      scale_q   <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      rd_cnt_q  <= '0;
      rcv_cnt_q <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      ppu_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      scale_q   <= scale_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      rd_cnt_q  <= rd_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      ppu_en_q  <= ppu_en_d;
      wr_en_q   <= wr_en_d;
      wr_last_q <= wr_last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign psum_rd_en    = (state_q == S_ISSUE);
  assign psum_rd_addr  = psum_rd_en ? raddr_q : '0;
  assign ppu_en        = ppu_en_q;
  assign ppu_data      = ppu_en_q ? psum_rd_data : 32'd0;
  assign ppu_scale     = scale_q;
  assign ofmap_wr_en   = wr_en_q;
  assign ofmap_wr_addr = wr_addr_q;
  assign ofmap_wr_data = wr_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_ppu_ctrl.sv
// Bench for ppu_ctrl: psum buffer and PPU are modelled behaviourally, and each
// job's expected writes are derived from the psum list with plain arithmetic.
module tb_ppu_ctrl;
  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk, rst, start;
  logic [CW-1:0] num_elem;
  logic [AW-1:0] psum_base, ofmap_base;
  logic [11:0]   scale_in;
  logic          psum_rd_en;
  logic [AW-1:0] psum_rd_addr;
  logic [31:0]   psum_rd_data;
  logic          ppu_en;
  logic [31:0]   ppu_data;
  logic [11:0]   ppu_scale;
  logic [7:0]    ppu_q;
  logic          ppu_valid, pv_q, inj_valid;
  logic          ofmap_wr_en;
  logic [AW-1:0] ofmap_wr_addr;
  logic [31:0]   ofmap_wr_data;
  logic          busy, done;

  ppu_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_elem(num_elem),
    .psum_base(psum_base), .ofmap_base(ofmap_base), .scale_in(scale_in),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data),
    .ppu_en(ppu_en), .ppu_data(ppu_data), .ppu_scale(ppu_scale),
    .ppu_q(ppu_q), .ppu_valid(ppu_valid),
    .ofmap_wr_en(ofmap_wr_en), .ofmap_wr_addr(ofmap_wr_addr), .ofmap_wr_data(ofmap_wr_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ReLU, integer divide, saturate to 255.
  function automatic logic [7:0] ppu_fn(input logic [31:0] d, input logic [11:0] s);
    longint x;
    x = longint'(signed'(d));
    if (x < 0) return 8'd0;
    x = x / longint'(s);
    if (x > 255) return 8'hFF;
    return 8'(x);
  endfunction

  logic [31:0] mem [0:4095];
  logic [31:0] psum [0:63];

  always @(posedge clk) begin
    psum_rd_data <= psum_rd_en ? mem[psum_rd_addr] : 32'hDEAD_BEEF;
    pv_q         <= ppu_en;
    ppu_q        <= ppu_en ? ppu_fn(ppu_data, ppu_scale) : 8'h5A;
  end
  assign ppu_valid = pv_q | inj_valid;

  int          rd_a[$], rd_c[$], wa[$], wc[$];
  logic [31:0] wd[$];
  int          done_cnt, done_cyc, busy_cnt, gate_bad;

  always @(negedge clk) begin
    if (!rst) begin
      if (psum_rd_en) begin rd_a.push_back(int'(psum_rd_addr)); rd_c.push_back(cyc); end
      if (ofmap_wr_en) begin
        wa.push_back(int'(ofmap_wr_addr)); wd.push_back(ofmap_wr_data); wc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (!ppu_en && ppu_data != 32'd0) gate_bad++;
    end
  end

  function automatic logic [31:0] exp_word(input int n, input int sc, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 4; j++)
      if (4*w + j < n) r |= 32'(ppu_fn(psum[4*w+j], 12'(sc))) << (8*j);
    return r;
  endfunction

  task automatic clear_mon();
    rd_a.delete(); rd_c.delete(); wa.delete(); wc.delete(); wd.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; gate_bad = 0;
  endtask

  // Called just after a falling edge; starts a job and waits (bounded) for done.
  task automatic run_job(input int n, input int pb, input int ob, input int sc,
                         input int inj_at, output bit tmo, output int s_cyc);
    for (int i = 0; i < n; i++) mem[(pb + i) & 12'hFFF] = psum[i];
    clear_mon();
    num_elem = CW'(n); psum_base = AW'(pb); ofmap_base = AW'(ob); scale_in = 12'(sc);
    start = 1'b1; s_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    num_elem = CW'($urandom); psum_base = AW'($urandom);
    ofmap_base = AW'($urandom); scale_in = 12'($urandom);
    tmo = 1'b1;
    for (int k = 0; k < 4*n + 40; k++) begin
      if (done_cnt > 0) begin tmo = 1'b0; break; end
      if (inj_at > 0 && k == inj_at) begin
        start = 1'b1; num_elem = 3; psum_base = 12'h200; ofmap_base = 12'h300; scale_in = 2;
      end else start = 1'b0;
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inj_valid = 1'b0;
    num_elem = '0; psum_base = '0; ofmap_base = '0; scale_in = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({psum_rd_en, psum_rd_addr, ppu_en, ppu_data, ppu_scale, ofmap_wr_en,
         ofmap_wr_addr, ofmap_wr_data, busy, done} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero, busy=%0b done=%0b rd_en=%0b", busy, done, psum_rd_en);
    end
    // Release reset and request a zero-length job for the very next edge.
    rst = 1'b0; start = 1'b1; num_elem = 0; scale_in = 12'd7;
    @(negedge clk); #1;
    start = 1'b0;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL reset_first_start: done=%0b required 1", done); end
    tests++;
    if (ppu_scale !== 12'd7) begin fails++; $display("FAIL reset_scale_latch: got %0d required 7", ppu_scale); end
    @(negedge clk); #1;
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_back_idle: busy/done=%b required 00", {busy, done}); end
  endtask

  task automatic test_full_words();
    bit tmo; int s;
    for (int i = 0; i < 8; i++) psum[i] = 32'(i + 1);
    @(negedge clk); #1;
    run_job(8, 'h010, 'h100, 1, 0, tmo, s);
    tests++; if (tmo) begin fails++; $display("FAIL full_timeout: no done"); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL full_nwrites: got %0d required 2", wa.size()); end
    tests++;
    if (wd[0] !== 32'h04030201 || wa[0] != 'h100) begin
      fails++; $display("FAIL full_word0: got %08h@%03h required 04030201@100", wd[0], wa[0]);
    end
    tests++;
    if (wd[1] !== 32'h08070605 || wa[1] != 'h101) begin
      fails++; $display("FAIL full_word1: got %08h@%03h required 08070605@101", wd[1], wa[1]);
    end
    tests++; if (done_cyc != wc[1] + 1) begin fails++; $display("FAIL full_done_time: got %0d required %0d", done_cyc, wc[1] + 1); end
    tests++; if (wc[0] != rd_c[3] + 3) begin fails++; $display("FAIL full_latency: write at %0d required %0d", wc[0], rd_c[3] + 3); end
    tests++; if (rd_c[0] != s + 1) begin fails++; $display("FAIL full_first_read: at %0d required %0d", rd_c[0], s + 1); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rd_a[i] != 'h010 + i) begin fails++; $display("FAIL full_rd_addr%0d: got %03h required %03h", i, rd_a[i], 'h010 + i); end
    end
    tests++; if (gate_bad != 0) begin fails++; $display("FAIL ppu_data_gate: %0d cycles nonzero with ppu_en low, required 0", gate_bad); end
  endtask

  task automatic test_partial();
    bit tmo; int s;
    psum[0] = 400; psum[1] = -7; psum[2] = 8; psum[3] = 12; psum[4] = 1020;
    @(negedge clk); #1;
    run_job(5, 'h040, 'h020, 4, 0, tmo, s);
    tests++; if (tmo) begin fails++; $display("FAIL partial_timeout: no done"); end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL partial_nwrites: got %0d required 2", wa.size()); end
    tests++; if (wd[0] !== 32'h03020064) begin fails++; $display("FAIL partial_word0: got %08h required 03020064", wd[0]); end
    tests++; if (wd[1] !== 32'h000000FF) begin fails++; $display("FAIL partial_word1: got %08h required 000000ff", wd[1]); end
    tests++; if (done_cyc != s + 9) begin fails++; $display("FAIL partial_done_time: got %0d required %0d", done_cyc, s + 9); end
    tests++; if (busy_cnt != 9) begin fails++; $display("FAIL partial_busy: %0d busy cycles required 9", busy_cnt); end
  endtask

  task automatic test_zero_len();
    bit tmo; int s;
    @(negedge clk); #1;
    run_job(0, 'h123, 'h456, 3, 0, tmo, s);
    tests++; if (rd_a.size() != 0 || wa.size() != 0) begin
      fails++; $display("FAIL zero_traffic: %0d reads %0d writes required 0/0", rd_a.size(), wa.size());
    end
    tests++; if (done_cnt != 1 || done_cyc != s + 1) begin
      fails++; $display("FAIL zero_done: %0d pulses at %0d required 1 at %0d", done_cnt, done_cyc, s + 1);
    end
  endtask

  task automatic test_wrap();
    bit tmo; int s;
    for (int i = 0; i < 8; i++) psum[i] = 32'(10 * i);
    @(negedge clk); #1;
    run_job(8, 'hFFE, 'hFFF, 1, 0, tmo, s);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rd_a[i] != (('hFFE + i) & 'hFFF)) begin
        fails++; $display("FAIL wrap_rd_addr%0d: got %03h required %03h", i, rd_a[i], ('hFFE + i) & 'hFFF);
      end
    end
    tests++;
    if (wa.size() != 2 || wa[0] != 'hFFF || wa[1] != 0) begin
      fails++; $display("FAIL wrap_wr_addr: n=%0d %03h,%03h required FFF,000", wa.size(), wa[0], wa[1]);
    end
  endtask

  task automatic test_busy_start();
    bit tmo; int s;
    for (int i = 0; i < 8; i++) psum[i] = 32'(3 * i + 5);
    @(negedge clk); #1;
    run_job(8, 'h080, 'h0A0, 3, 2, tmo, s);
    tests++; if (rd_a.size() != 8 || rd_a[7] != 'h087) begin
      fails++; $display("FAIL busy_reads: %0d reads last %03h required 8 last 087", rd_a.size(), rd_a[7]);
    end
    tests++; if (wa.size() != 2) begin fails++; $display("FAIL busy_nwrites: got %0d required 2", wa.size()); end
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (wd[w] !== exp_word(8, 3, w) || wa[w] != 'h0A0 + w) begin
        fails++; $display("FAIL busy_word%0d: got %08h@%03h required %08h@%03h", w, wd[w], wa[w], exp_word(8, 3, w), 'h0A0 + w);
      end
    end
    tests++; if (ppu_scale !== 12'd3 || busy !== 1'b0 || done_cnt != 1) begin
      fails++; $display("FAIL busy_ignored: scale=%0d busy=%0b dones=%0d required 3/0/1", ppu_scale, busy, done_cnt);
    end
  endtask

  task automatic test_reset_midjob();
    bit tmo; int s; bit seen;
    for (int i = 0; i < 8; i++) psum[i] = 32'(i + 1);
    for (int i = 0; i < 8; i++) mem[('h300 + i) & 12'hFFF] = psum[i];
    @(negedge clk); #1;
    clear_mon();
    num_elem = 8; psum_base = 12'h300; ofmap_base = 12'h050; scale_in = 1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (rd_a.size() == 8) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL midrst_reads: %0d reads required 8", rd_a.size()); end
    @(negedge clk); #1;
    tests++; if (busy !== 1'b1 || psum_rd_en !== 1'b0) begin
      fails++; $display("FAIL midrst_drain: busy=%0b rd_en=%0b required 1/0", busy, psum_rd_en);
    end
    rst = 1'b1; #1;
    tests++;
    if ({psum_rd_en, psum_rd_addr, ppu_en, ppu_data, ppu_scale, ofmap_wr_en,
         ofmap_wr_addr, ofmap_wr_data, busy, done} !== '0) begin
      fails++; $display("FAIL midrst_outputs: busy=%0b wr_en=%0b scale=%0d required all 0", busy, ofmap_wr_en, ppu_scale);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    tests++; if (wa.size() != 1 || done_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_abort: %0d writes %0d dones busy=%0b required 1/0/0", wa.size(), done_cnt, busy);
    end
    run_job(8, 'h010, 'h200, 1, 0, tmo, s);
    tests++;
    if (tmo || wa.size() != 2 || wd[0] !== 32'h04030201 || wd[1] !== 32'h08070605 || wa[1] != 'h201) begin
      fails++; $display("FAIL midrst_fresh: n=%0d %08h %08h@%03h required 2 04030201 08070605@201", wa.size(), wd[0], wd[1], wa[1]);
    end
  endtask

  task automatic test_random();
    bit tmo; int s, n, pb, ob, sc, nw;
    for (int j = 0; j < 10; j++) begin
      n  = $urandom_range(0, 13);
      pb = $urandom_range(0, 4095);
      ob = $urandom_range(0, 4095);
      sc = (j == 9) ? 1 : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) psum[i] = 32'($urandom_range(0, 3000)) - 32'd600;
      // A stray valid while idle must not land in any lane.
      @(negedge clk); #1; inj_valid = 1'b1;
      @(negedge clk); #1; inj_valid = 1'b0;
      run_job(n, pb, ob, sc, 0, tmo, s);
      nw = (n + 3) / 4;
      tests++; if (tmo) begin fails++; $display("FAIL rand%0d_timeout: no done", j); end
      tests++; if (wa.size() != nw || rd_a.size() != n) begin
        fails++; $display("FAIL rand%0d_counts: %0d writes %0d reads required %0d/%0d", j, wa.size(), rd_a.size(), nw, n);
      end
      for (int w = 0; w < nw; w++) begin
        tests++;
        if (wd[w] !== exp_word(n, sc, w) || wa[w] != ((ob + w) & 'hFFF)) begin
          fails++; $display("FAIL rand%0d_word%0d: got %08h@%03h required %08h@%03h", j, w, wd[w], wa[w], exp_word(n, sc, w), (ob + w) & 'hFFF);
        end
      end
      tests++;
      if (done_cnt != 1 || done_cyc != ((n == 0) ? s + 1 : s + n + 4)) begin
        fails++; $display("FAIL rand%0d_done: %0d pulses at %0d required 1 at %0d", j, done_cnt, done_cyc, (n == 0) ? s + 1 : s + n + 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_zero_len();
    test_wrap();
    test_busy_start();
    test_reset_midjob();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ppu_ctrl.md
PPU_CTRL -- requirements
Module: ppu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: width of the psum and ofmap buffer addresses.
REQ-002 Parameter CNT_W, default 16: width of the element-count field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-006 num_elem  input  CNT_W  count of 32-bit psums in the job; latched at start.
REQ-007 psum_base  input  ADDR_W  first psum buffer address; latched at start.
REQ-008 ofmap_base  input  ADDR_W  first ofmap buffer word address; latched at start.
REQ-009 scale_in  input  12  PPU divisor; latched at start.
REQ-010 psum_rd_en  output  1  psum buffer read strobe.
REQ-011 psum_rd_addr  output  ADDR_W  psum buffer read address.
REQ-012 psum_rd_data  input  32  psum buffer read data; valid exactly 1 cycle after psum_rd_en.
REQ-013 ppu_en  output  1  PPU i_en.
REQ-014 ppu_data  output  32  PPU data_in.
REQ-015 ppu_scale  output  12  PPU scaling_factor; holds the latched scale.
REQ-016 ppu_q  input  8  PPU data_out; registered, 1 cycle after ppu_en.
REQ-017 ppu_valid  input  1  PPU valid.
REQ-018 ofmap_wr_en  output  1  ofmap buffer write strobe; no backpressure.
REQ-019 ofmap_wr_addr  output  ADDR_W  ofmap buffer word address.
REQ-020 ofmap_wr_data  output  32  four packed int8 results.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle completion pulse.

Function
REQ-023 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-024 IDLE -> ISSUE SHALL occur on start with num_elem>0; IDLE -> DONE SHALL occur on start with num_elem==0, with no reads and no writes.
REQ-025 In ISSUE, psum_rd_en SHALL be high on each of num_elem consecutive cycles, with addresses psum_base, psum_base+1, ..., wrapping modulo 2^ADDR_W.
REQ-026 ISSUE -> DRAIN SHALL occur after the last read is issued.
REQ-027 ppu_en SHALL be psum_rd_en delayed 1 cycle, and ppu_data SHALL be psum_rd_data in that cycle; ppu_data SHALL be 0 when ppu_en is low.
REQ-028 The packer SHALL place each byte of ppu_q that arrives with ppu_valid into lane k of the output word, at bits [8k+7:8k], with k=0..3 in arrival order.
REQ-029 The packer SHALL assert ofmap_wr_en for one cycle when lane 3 is filled, or when the job's final byte is captured.
REQ-030 For a partial final word, unfilled lanes SHALL be 0.
REQ-031 ofmap_wr_en, ofmap_wr_addr and ofmap_wr_data SHALL be registered, so a write appears 1 cycle after its final byte's ppu_valid.
REQ-032 ofmap_wr_addr SHALL start at ofmap_base and increment by 1 per write, wrapping modulo 2^ADDR_W.
REQ-033 End-to-end latency SHALL be 3 cycles from a psum_rd_en to the ofmap write that contains its byte, when that byte completes the word.
REQ-034 DRAIN -> DONE SHALL occur in the cycle after the final write.
REQ-035 DONE SHALL assert done for 1 cycle and then return to IDLE.
REQ-036 A start while busy is high SHALL be ignored, and the latched fields SHALL be unchanged.
REQ-037 The block SHALL count received bytes independently of issued reads, and "final byte" SHALL mean byte count equals the latched num_elem.
REQ-038 Total writes per job SHALL be ceil(num_elem/4).
REQ-039 ppu_valid while in IDLE or DONE SHALL be ignored.

Reset
REQ-040 On rst, the FSM SHALL go to IDLE and all outputs SHALL be 0, including ppu_scale.
REQ-041 On rst, all counters, the lane index and the pack register SHALL clear.
REQ-042 A reset mid-job SHALL abort the job with no done pulse and no further writes.
REQ-043 After reset deassertion, the block SHALL accept start on the first following rising edge.

Verification
REQ-044 Full words: num_elem=8, psum_base=0x010, ofmap_base=0x100, scale=1, psums=1..8 -> writes 0x04030201@0x100 and 0x08070605@0x101, then done 1 cycle after the second write.
REQ-045 Partial word and ReLU/divide: num_elem=5, scale=4, psums {400,-7,8,12,1020} -> writes 0x03020064 then 0x000000FF, busy high until done.
REQ-046 Zero length: num_elem=0 -> no psum_rd_en, no ofmap_wr_en, done 1 cycle after the start edge.
REQ-047 Address wrap: ADDR_W=12, psum_base=0xFFE, ofmap_base=0xFFF, num_elem=8 -> read addresses 0xFFE,0xFFF,0x000..0x005, write addresses 0xFFF then 0x000.
REQ-048 Start while busy: a second start with different fields during ISSUE -> ignored, exactly ceil(N/4) writes for the first job only.
REQ-049 Reset mid-job: assert rst during DRAIN of an 8-element job -> all outputs 0 the same cycle, no done, and a fresh job after release completes correctly.
